// File: rtl/ex_simple_pipe.sv
// Simple-op execute pipe: oldest-ready RS select, E1 operand stage,
// ALU, E2 result stage with valid/ready retire toward ROB/CDB.
module alu (
  input  logic [5:0]  aluop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  // Integer op decode; unknown ops yield zero.
  always_comb begin
    y = '0;
    case (aluop)
      6'd0: y = a + b;
      6'd1: y = a - b;
      6'd2: y = a & b;
      6'd3: y = a | b;
      6'd4: y = a ^ b;
      6'd5: y = a << b[4:0];
      6'd6: y = a >> b[4:0];
      6'd7: y = $signed(a) >>> b[4:0];
      6'd8: y = {31'b0, $signed(a) < $signed(b)};
      6'd9: y = {31'b0, a < b};
      default: y = '0;
    endcase
  end
endmodule

module ex_simple_pipe #(
  parameter int NUM_RS = 4,
  parameter int AGE_W  = 4,
  parameter int ROB_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_RS-1:0]       rs_occupied,
  input  logic [NUM_RS*114-1:0]   rs_payload,
  input  logic [NUM_RS*AGE_W-1:0] rs_age,
  input  logic [NUM_RS*ROB_W-1:0] rs_rob_num,
  output logic [NUM_RS-1:0]       rs_issue,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [74:0]             executed_inst,
  output logic [ROB_W-1:0]        out_rob_num,
  output logic [31:0]             writeData,
  output logic [4:0]              writeAddr,
  output logic                    writeEn
);
  localparam int PW    = 114;
  localparam int SEL_W = $clog2(NUM_RS);

  logic [NUM_RS-1:0] elig;
  logic              found;
  logic [SEL_W-1:0]  sel;
  logic [AGE_W-1:0]  best;
  logic [PW-1:0]     sel_word;
  logic [ROB_W-1:0]  sel_rob;
  logic              grant;
  logic              advance_e1;
  logic              advance_e2;
  logic              unused_bits;

  logic             e1_valid;
  logic [31:0]      e1_s1;
  logic [31:0]      e1_s2;
  logic [5:0]       e1_aluop;
  logic [4:0]       e1_rd;
  logic             e1_rw;
  logic [ROB_W-1:0] e1_rob;

  logic             e2_valid;
  logic [31:0]      e2_result;
  logic [4:0]       e2_rd;
  logic             e2_rw;
  logic [ROB_W-1:0] e2_rob;

  logic [31:0] alu_y;

  // Oldest eligible entry wins; strict compare keeps ties on lowest index.
  always_comb begin
    elig  = '0;
    found = 1'b0;
    sel   = '0;
    best  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      elig[i] = rs_occupied[i] & rs_payload[i*PW+5]
              & rs_payload[i*PW+38];
      if (elig[i] &&
          (!found || rs_age[i*AGE_W +: AGE_W] < best)) begin
        found = 1'b1;
        sel   = SEL_W'(i);
        best  = rs_age[i*AGE_W +: AGE_W];
      end
    end
  end

  assign sel_word = rs_payload[sel*PW +: PW];
  assign sel_rob  = rs_rob_num[sel*ROB_W +: ROB_W];
  assign unused_bits = ^{sel_word[PW-1:82], sel_word[75:72],
                         sel_word[38], sel_word[5]};

  assign advance_e2 = !e2_valid | out_ready;
  assign advance_e1 = !e1_valid | advance_e2;
  assign grant      = found & advance_e1 & !flush & !rst;
  assign rs_issue   = grant ? (NUM_RS'(1) << sel) : '0;

  // E1: capture operands of the granted entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      e1_valid <= 1'b0;
      e1_s1    <= '0;
      e1_s2    <= '0;
      e1_aluop <= '0;
      e1_rd    <= '0;
      e1_rw    <= 1'b0;
      e1_rob   <= '0;
    end else if (flush) begin
      e1_valid <= 1'b0;
    end else if (advance_e1) begin
      e1_valid <= grant;
      if (grant) begin
        e1_s1    <= sel_word[37:6];
        e1_s2    <= sel_word[70:39];
        e1_aluop <= sel_word[81:76];
        e1_rd    <= sel_word[4:0];
        e1_rw    <= sel_word[71];
        e1_rob   <= sel_rob;
      end
    end
  end

  alu u_alu (
    .aluop (e1_aluop),
    .a     (e1_s1),
    .b     (e1_s2),
    .y     (alu_y)
  );

  // E2: hold the ALU result until the ROB/CDB takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      e2_valid  <= 1'b0;
      e2_result <= '0;
      e2_rd     <= '0;
      e2_rw     <= 1'b0;
      e2_rob    <= '0;
    end else if (flush) begin
      e2_valid <= 1'b0;
    end else if (advance_e2) begin
      e2_valid <= e1_valid;
      if (e1_valid) begin
        e2_result <= alu_y;
        e2_rd     <= e1_rd;
        e2_rw     <= e1_rw;
        e2_rob    <= e1_rob;
      end
    end
  end

  assign out_valid     = e2_valid & !rst;
  assign writeEn       = out_valid & out_ready & e2_rw & !flush;
  assign writeData     = e2_result;
  assign writeAddr     = e2_rd;
  assign out_rob_num   = e2_rob;
  assign executed_inst = {37'b0, e2_rw, e2_result, e2_rd};
endmodule

// File: tb/tb_ex_simple_pipe.sv
// Directed bench for ex_simple_pipe with a queue scoreboard
// checked by a monitor on every accepted result.
module tb_ex_simple_pipe;
  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [3:0]    rs_occupied;
  logic [455:0]  rs_payload;
  logic [15:0]   rs_age;
  logic [15:0]   rs_rob_num;
  logic [3:0]    rs_issue;
  logic          out_valid;
  logic          out_ready;
  logic [74:0]   executed_inst;
  logic [3:0]    out_rob_num;
  logic [31:0]   writeData;
  logic [4:0]    writeAddr;
  logic          writeEn;

  typedef struct packed {
    logic [3:0]  rob;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   run     = 1'b0;
  logic [3:0] seen;

  always #5 clk = ~clk;

  ex_simple_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .rs_occupied   (rs_occupied),
    .rs_payload    (rs_payload),
    .rs_age        (rs_age),
    .rs_rob_num    (rs_rob_num),
    .rs_issue      (rs_issue),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .executed_inst (executed_inst),
    .out_rob_num   (out_rob_num),
    .writeData     (writeData),
    .writeAddr     (writeAddr),
    .writeEn       (writeEn)
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [113:0] mk(input logic [4:0] rd,
                                      input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [5:0] op,
                                      input logic rw);
    logic [113:0] w;
    w = '0;
    w[4:0]    = rd;
    w[5]      = 1'b1;
    w[37:6]   = a;
    w[38]     = 1'b1;
    w[70:39]  = b;
    w[71]     = rw;
    w[75:72]  = 4'hF;
    w[81:76]  = op;
    w[113:82] = 32'hDEADBEEF;
    return w;
  endfunction

  function automatic exp_t ex(input logic [3:0] rob,
                              input logic [4:0] rd,
                              input logic [31:0] d,
                              input logic rw);
    exp_t e;
    e.rob  = rob;
    e.rd   = rd;
    e.data = d;
    e.rw   = rw;
    return e;
  endfunction

  task automatic put(input int i, input logic [113:0] w,
                     input logic [3:0] age, input logic [3:0] rob);
    rs_payload[i*114 +: 114] = w;
    rs_age[i*4 +: 4]         = age;
    rs_rob_num[i*4 +: 4]     = rob;
    rs_occupied[i]           = 1'b1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic adv();
    seen = rs_issue;
    @(posedge clk);
    #1;
    rs_occupied = rs_occupied & ~seen;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (q.size() != 0 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(nm, q.size(), 0);
  endtask

  // Scoreboard monitor: every accepted result must match the queue head.
  always @(negedge clk) begin
    if (run) begin
      if (rst || flush) begin
        chk("wen_blocked", writeEn, 1'b0);
      end else if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result",
              {writeEn, writeData, writeAddr, out_rob_num,
               executed_inst},
              {e.rw, e.data, e.rd, e.rob,
               {37'b0, e.rw, e.data, e.rd}});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [113:0] w;
    rst         = 1'b1;
    flush       = 1'b0;
    out_ready   = 1'b1;
    rs_occupied = '0;
    rs_payload  = '0;
    rs_age      = '0;
    rs_rob_num  = '0;
    run         = 1'b1;

    // Reset: entry 2 eligible but grant must stay off.
    w = mk(5'd3, 32'd5, 32'd7, 6'd0, 1'b1);
    put(2, w, 4'd3, 4'd9);
    w = mk(5'd1, 32'd1, 32'd1, 6'd0, 1'b1);
    w[38] = 1'b0;
    put(0, w, 4'd0, 4'd1);
    q.push_back(ex(4'd9, 5'd3, 32'd12, 1'b1));
    at_neg();
    chk("rst_issue", rs_issue, 4'b0000);
    chk("rst_valid", out_valid, 1'b0);
    @(posedge clk);
    at_neg();
    chk("rst_wen", writeEn, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single ADD, 2-cycle latency; entry 0 lacks s2 and is skipped.
    at_neg();
    chk("post_rst_inst", executed_inst, 75'd0);
    chk("post_rst_rob", out_rob_num, 4'd0);
    chk("post_rst_valid", out_valid, 1'b0);
    chk("issue_e2", rs_issue, 4'b0100);
    adv();
    at_neg();
    chk("lat_n1_valid", out_valid, 1'b0);
    adv();
    at_neg();
    chk("lat_n2_valid", out_valid, 1'b1);
    chk("lat_n2_wen", writeEn, 1'b1);
    chk("lat_n2_data", writeData, 32'd12);
    adv();
    rs_occupied[0] = 1'b0;
    drain("drain_t1");

    // Age ordering with tie on lowest index.
    put(0, mk(5'd1, 32'd20, 32'd3, 6'd1, 1'b1), 4'd5, 4'd1);
    put(1, mk(5'd2, 32'hF0F0, 32'hFF00, 6'd2, 1'b1), 4'd2, 4'd2);
    put(3, mk(5'd4, 32'hAAAA, 32'h5555, 6'd4, 1'b0), 4'd2, 4'd3);
    q.push_back(ex(4'd2, 5'd2, 32'h0000F000, 1'b1));
    q.push_back(ex(4'd3, 5'd4, 32'h0000FFFF, 1'b0));
    q.push_back(ex(4'd1, 5'd1, 32'd17, 1'b1));
    at_neg();
    chk("age_first", rs_issue, 4'b0010);
    adv();
    at_neg();
    chk("age_tie", rs_issue, 4'b1000);
    adv();
    at_neg();
    chk("age_last", rs_issue, 4'b0001);
    adv();
    drain("drain_t2");

    // Backpressure: two issues then stall, E2 payload stable.
    out_ready = 1'b0;
    put(0, mk(5'd5, 32'h0F, 32'hF0, 6'd3, 1'b1), 4'd0, 4'd4);
    put(1, mk(5'd6, 32'd100, 32'd200, 6'd0, 1'b1), 4'd1, 4'd5);
    put(2, mk(5'd7, 32'd1, 32'd2, 6'd1, 1'b1), 4'd2, 4'd6);
    q.push_back(ex(4'd4, 5'd5, 32'hFF, 1'b1));
    q.push_back(ex(4'd5, 5'd6, 32'd300, 1'b1));
    q.push_back(ex(4'd6, 5'd7, 32'hFFFFFFFF, 1'b1));
    at_neg();
    chk("bp_issue0", rs_issue, 4'b0001);
    adv();
    at_neg();
    chk("bp_issue1", rs_issue, 4'b0010);
    adv();
    at_neg();
    chk("bp_stall2", rs_issue, 4'b0000);
    chk("bp_valid2", out_valid, 1'b1);
    chk("bp_hold2", {out_rob_num, executed_inst},
        {4'd4, 37'b0, 1'b1, 32'hFF, 5'd5});
    adv();
    at_neg();
    chk("bp_stall3", rs_issue, 4'b0000);
    chk("bp_valid3", out_valid, 1'b1);
    chk("bp_hold3", {out_rob_num, executed_inst},
        {4'd4, 37'b0, 1'b1, 32'hFF, 5'd5});
    chk("bp_wen3", writeEn, 1'b0);
    adv();
    out_ready = 1'b1;
    at_neg();
    chk("bp_resume", rs_issue, 4'b0100);
    adv();
    drain("drain_t3");

    // Flush with E1 and E2 both valid.
    put(0, mk(5'd8, 32'd1, 32'd1, 6'd0, 1'b1), 4'd0, 4'd7);
    put(1, mk(5'd9, 32'd2, 32'd2, 6'd0, 1'b1), 4'd1, 4'd8);
    at_neg();
    chk("fl_issue0", rs_issue, 4'b0001);
    adv();
    at_neg();
    chk("fl_issue1", rs_issue, 4'b0010);
    adv();
    flush = 1'b1;
    put(2, mk(5'd10, 32'd10, 32'd20, 6'd0, 1'b1), 4'd0, 4'd10);
    at_neg();
    chk("fl_no_grant", rs_issue, 4'b0000);
    chk("fl_no_wen", writeEn, 1'b0);
    adv();
    flush = 1'b0;
    q.push_back(ex(4'd10, 5'd10, 32'd30, 1'b1));
    at_neg();
    chk("fl_valid_cleared", out_valid, 1'b0);
    chk("fl_regrant", rs_issue, 4'b0100);
    adv();
    drain("drain_t4");

    // Mid-flight reset, then a fresh op.
    put(0, mk(5'd11, 32'd3, 32'd4, 6'd0, 1'b1), 4'd0, 4'd11);
    put(1, mk(5'd12, 32'd9, 32'd4, 6'd1, 1'b1), 4'd1, 4'd12);
    at_neg();
    chk("rs_issue0", rs_issue, 4'b0001);
    adv();
    at_neg();
    chk("rs_issue1", rs_issue, 4'b0010);
    adv();
    rst = 1'b1;
    at_neg();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_issue", rs_issue, 4'b0000);
    adv();
    rst = 1'b0;
    at_neg();
    chk("after_rst_outs",
        {out_valid, writeEn, rs_issue, out_rob_num, writeData,
         executed_inst}, 128'd0);
    adv();
    put(3, mk(5'd13, 32'h100, 32'h011, 6'd3, 1'b1), 4'd0, 4'd13);
    q.push_back(ex(4'd13, 5'd13, 32'h111, 1'b1));
    at_neg();
    chk("new_issue", rs_issue, 4'b1000);
    adv();
    at_neg();
    chk("new_n1_valid", out_valid, 1'b0);
    adv();
    at_neg();
    chk("new_n2_valid", out_valid, 1'b1);
    chk("new_n2_data", writeData, 32'h111);
    adv();
    drain("drain_t5");

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
